// File: rtl/cam_capture.sv
// cam_capture: oversamples an OV7670-style camera bus and assembles RGB565 pixels
// tagged with x/y coordinates and frame/line markers, all on the system clock.
module cam_capture #(
  parameter int H_ACTIVE    = 320,
  parameter int V_ACTIVE    = 240,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        enable_i,
  input  logic        cam_pclk_i,
  input  logic        cam_vsync_i,
  input  logic        cam_href_i,
  input  logic [7:0]  cam_data_i,
  output logic [15:0] pix_data_o,
  output logic        pix_valid_o,
  output logic [8:0]  pix_x_o,
  output logic [7:0]  pix_y_o,
  output logic        frame_start_o,
  output logic        line_end_o,
  output logic        frame_done_o,
  output logic        err_o,
  output logic        busy_o
);
  typedef enum logic [1:0] {IDLE, WAIT_VS, ACTIVE} state_t;
  localparam logic [8:0] X_MAX = 9'(H_ACTIVE);
  localparam logic [7:0] Y_MAX = 8'(V_ACTIVE);
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] pclk_sync_q, pclk_sync_d, vs_sync_q, vs_sync_d, href_sync_q, href_sync_d;
  logic [SYNC_STAGES-1:0][7:0] data_sync_q, data_sync_d;
  logic pclk_dly_q, pclk_dly_d, vs_dly_q, vs_dly_d, href_smp_q, href_smp_d;
  logic phase_q, phase_d, drop_q, drop_d;
  logic [7:0] hi_q, hi_d;
  logic [8:0] x_q, x_d, pix_x_q, pix_x_d;
  logic [7:0] y_q, y_d, pix_y_q, pix_y_d;
  logic [15:0] pix_data_q, pix_data_d;
  logic pix_valid_q, pix_valid_d, fs_q, fs_d, le_q, le_d, fd_q, fd_d, err_q, err_d;
  logic pclk_s, vs_s, href_s, pclk_rise, vs_rise, vs_fall, href_rise, href_fall, line_drop;
  logic [7:0] data_s;
  assign pclk_s    = pclk_sync_q[SYNC_STAGES-1];
  assign vs_s      = vs_sync_q[SYNC_STAGES-1];
  assign href_s    = href_sync_q[SYNC_STAGES-1];
  assign data_s    = data_sync_q[SYNC_STAGES-1];
  assign pclk_rise = pclk_s & ~pclk_dly_q;
  assign vs_rise   = vs_s & ~vs_dly_q;
  assign vs_fall   = ~vs_s & vs_dly_q;
  assign href_rise = pclk_rise & href_s & ~href_smp_q;
  assign href_fall = pclk_rise & ~href_s & href_smp_q;
  // A line that begins once all rows are filled is swallowed whole.
  assign line_drop = drop_q | (href_rise & (y_q == Y_MAX));
  always_comb begin
    pclk_sync_d = {pclk_sync_q[SYNC_STAGES-2:0], cam_pclk_i};
    vs_sync_d   = {vs_sync_q[SYNC_STAGES-2:0], cam_vsync_i};
    href_sync_d = {href_sync_q[SYNC_STAGES-2:0], cam_href_i};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], cam_data_i};
    pclk_dly_d  = pclk_s;
    vs_dly_d    = vs_s;
    href_smp_d  = pclk_rise ? href_s : href_smp_q;
    state_d     = state_q;
    phase_d     = phase_q;
    drop_d      = drop_q;
    hi_d        = hi_q;
    x_d         = x_q;
    y_d         = y_q;
    pix_data_d  = pix_data_q;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    err_d       = err_q;
    pix_valid_d = 1'b0;
    fs_d        = 1'b0;
    le_d        = 1'b0;
    fd_d        = 1'b0;
    case (state_q)
      IDLE: state_d = (enable_i && vs_s) ? WAIT_VS : IDLE;
      WAIT_VS: begin
        if (!enable_i) state_d = IDLE;
        else if (vs_fall) begin
          state_d = ACTIVE;
          fs_d    = 1'b1;
          x_d     = '0;
          y_d     = '0;
          phase_d = 1'b0;
          drop_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      ACTIVE: begin
        if (href_rise && y_q == Y_MAX) begin
          drop_d = 1'b1;
          err_d  = 1'b1;
        end
        if (pclk_rise && href_s && !line_drop) begin
          phase_d = ~phase_q;
          if (!phase_q) hi_d = data_s;
          else if (x_q == X_MAX) err_d = 1'b1;
          else begin
            pix_valid_d = 1'b1;
            pix_data_d  = {hi_q, data_s};
            pix_x_d     = x_q;
            pix_y_d     = y_q;
            x_d         = x_q + 9'd1;
          end
        end
        if (href_fall) begin
          drop_d = 1'b0;
          if (!drop_q) begin
            le_d    = 1'b1;
            y_d     = y_q + 8'd1;
            x_d     = '0;
            phase_d = 1'b0;
            if (phase_q || x_q != X_MAX) err_d = 1'b1;
          end
        end
        // Frame ends here even if incomplete; an open line or missing rows flag an error.
        if (vs_rise) begin
          state_d = IDLE;
          fd_d    = 1'b1;
          phase_d = 1'b0;
          drop_d  = 1'b0;
          if (href_smp_d || y_d != Y_MAX) err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      pclk_sync_q <= '0;
      vs_sync_q   <= '0;
      href_sync_q <= '0;
      data_sync_q <= '0;
      pclk_dly_q  <= 1'b0;
      vs_dly_q    <= 1'b0;
      href_smp_q  <= 1'b0;
      phase_q     <= 1'b0;
      drop_q      <= 1'b0;
      hi_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      pix_data_q  <= '0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_valid_q <= 1'b0;
      fs_q        <= 1'b0;
      le_q        <= 1'b0;
      fd_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pclk_sync_q <= pclk_sync_d;
      vs_sync_q   <= vs_sync_d;
      href_sync_q <= href_sync_d;
      data_sync_q <= data_sync_d;
      pclk_dly_q  <= pclk_dly_d;
      vs_dly_q    <= vs_dly_d;
      href_smp_q  <= href_smp_d;
      phase_q     <= phase_d;
      drop_q      <= drop_d;
      hi_q        <= hi_d;
      x_q         <= x_d;
      y_q         <= y_d;
      pix_data_q  <= pix_data_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_valid_q <= pix_valid_d;
      fs_q        <= fs_d;
      le_q        <= le_d;
      fd_q        <= fd_d;
      err_q       <= err_d;
    end
  end
  assign pix_data_o    = pix_data_q;
  assign pix_valid_o   = pix_valid_q;
  assign pix_x_o       = pix_x_q;
  assign pix_y_o       = pix_y_q;
  assign frame_start_o = fs_q;
  assign line_end_o    = le_q;
  assign frame_done_o  = fd_q;
  assign err_o         = err_q;
  assign busy_o        = state_q != IDLE;
endmodule

// File: tb/tb_cam_capture.sv
// tb_cam_capture: randomized camera frames against a frame/line-level model;
// expected pixels go to a scoreboard that a free-running monitor drains.
module tb_cam_capture;
  localparam int H = 4, V = 2, SS = 2;
  logic clk = 0, rst_ni = 0, enable_i = 0, cam_pclk_i = 0, cam_vsync_i = 0, cam_href_i = 0;
  logic [7:0] cam_data_i = 0;
  logic [15:0] pix_data_o;
  logic [8:0] pix_x_o;
  logic [7:0] pix_y_o;
  logic pix_valid_o, frame_start_o, line_end_o, frame_done_o, err_o, busy_o;
  cam_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .SYNC_STAGES(SS)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable_i), .cam_pclk_i(cam_pclk_i),
    .cam_vsync_i(cam_vsync_i), .cam_href_i(cam_href_i), .cam_data_i(cam_data_i),
    .pix_data_o(pix_data_o), .pix_valid_o(pix_valid_o), .pix_x_o(pix_x_o), .pix_y_o(pix_y_o),
    .frame_start_o(frame_start_o), .line_end_o(line_end_o), .frame_done_o(frame_done_o),
    .err_o(err_o), .busy_o(busy_o)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  int fs_cnt = 0, le_cnt = 0, fd_cnt = 0, exp_fs = 0, exp_le = 0, exp_fd = 0, my = 0;
  bit exp_err = 0;
  logic [32:0] sb[$];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    fs_cnt += int'(frame_start_o);
    le_cnt += int'(line_end_o);
    fd_cnt += int'(frame_done_o);
    if (pix_valid_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got %0h/%0d/%0d expected none", pix_data_o, pix_x_o, pix_y_o);
      end else chk("pixel", {pix_data_o, pix_x_o, pix_y_o}, sb.pop_front());
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  task automatic cam_byte(input logic h, input logic [7:0] d);
    cam_pclk_i = 0;
    cam_href_i = h;
    cam_data_i = d;
    repeat (4) @(negedge clk);
    cam_pclk_i = 1;
    repeat (4) @(negedge clk);
  endtask
  task automatic idle(input int n);
    repeat (n) cam_byte(0, 8'h00);
  endtask
  task automatic send_line(input int nb, input bit pat, input bit cap);
    logic [7:0] b[$];
    for (int i = 0; i < nb; i++) b.push_back(pat ? 8'(8'h11 * (i + 1)) : 8'($urandom));
    if (cap) begin
      if (my == V) exp_err = 1;
      else begin
        for (int k = 0; k < nb / 2; k++)
          if (k < H) sb.push_back({b[2*k], b[2*k+1], 9'(k), 8'(my)});
        if (nb % 2 == 1 || nb / 2 != H) exp_err = 1;
        exp_le++;
        my++;
      end
    end
    foreach (b[i]) cam_byte(1, b[i]);
    idle(3);
    if (cap) chk("err_after_line", err_o, exp_err);
  endtask
  task automatic frame_begin(input bit cap);
    if (cap) chk("err_before_start", err_o, exp_err);
    cam_vsync_i = 1;
    idle(3);
    cam_vsync_i = 0;
    if (cap) begin
      exp_fs++;
      my = 0;
      exp_err = 0;
    end
    idle(2);
    if (cap) begin
      chk("err_cleared_at_start", err_o, exp_err);
      chk("busy_active", busy_o, 1);
    end
  endtask
  task automatic frame_end(input bit cap);
    cam_vsync_i = 1;
    if (cap) begin
      exp_fd++;
      if (my != V) exp_err = 1;
    end
    idle(2);
    if (cap) chk("err_at_frame_end", err_o, exp_err);
  endtask
  task automatic check_counts();
    chk("frame_start_count", fs_cnt, exp_fs);
    chk("line_end_count", le_cnt, exp_le);
    chk("frame_done_count", fd_cnt, exp_fd);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", {pix_data_o, pix_valid_o, pix_x_o, pix_y_o, frame_start_o, line_end_o, frame_done_o, err_o, busy_o}, 0);
    rst_ni = 1;
    enable_i = 1;
    frame_begin(1);
    send_line(8, 1, 1);
    send_line(8, 1, 1);
    frame_end(1);
    check_counts();
    frame_begin(1);
    sb.push_back({8'hA5, 8'h5A, 9'd0, 8'd0});
    cam_byte(1, 8'hA5);
    cam_pclk_i = 0;
    cam_data_i = 8'h5A;
    repeat (4) @(negedge clk);
    cam_pclk_i = 1;
    @(posedge clk);
    @(posedge clk);
    #1 chk("latency_e0p1", pix_valid_o, 0);
    @(posedge clk);
    #1 chk("latency_e0p2", pix_valid_o, 1);
    @(posedge clk);
    #1 chk("latency_e0p3", pix_valid_o, 0);
    @(negedge clk);
    idle(3);
    exp_le++;
    my++;
    exp_err = 1;
    chk("err_after_short_line", err_o, exp_err);
    send_line(8, 0, 1);
    frame_end(1);
    frame_begin(1);
    send_line(6, 0, 1);
    send_line(7, 0, 1);
    frame_end(1);
    check_counts();
    enable_i = 0;
    frame_begin(0);
    send_line(8, 0, 0);
    enable_i = 1;
    send_line(8, 0, 0);
    frame_end(0);
    frame_begin(1);
    send_line(8, 0, 1);
    enable_i = 0;
    send_line(8, 0, 1);
    frame_end(1);
    chk("busy_after_disable", busy_o, 0);
    check_counts();
    enable_i = 1;
    frame_begin(1);
    send_line(12, 0, 1);
    send_line(8, 0, 1);
    send_line(8, 0, 1);
    frame_end(1);
    check_counts();
    frame_begin(1);
    for (int k = 0; k < 3; k++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = 8'($urandom);
      sb.push_back({a, b, 9'(k), 8'(my)});
      cam_byte(1, a);
      cam_byte(1, b);
    end
    rst_ni = 0;
    #1 chk("reset_midline_outputs", {pix_data_o, pix_valid_o, pix_x_o, pix_y_o, frame_start_o, line_end_o, frame_done_o, err_o, busy_o}, 0);
    exp_err = 0;
    repeat (3) @(negedge clk);
    rst_ni = 1;
    cam_href_i = 0;
    send_line(8, 0, 0);
    frame_begin(1);
    send_line(8, 0, 1);
    send_line(8, 0, 1);
    frame_end(1);
    check_counts();
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
